// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, ALU operation codes, control-bundle bit positions and the
// opcode decoder for the ID/EX control stage.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned AOP_W  = 3;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned CTRL_W = 11;

    localparam logic [OP_W-1:0] OP_ADD  = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 5'h02;
    localparam logic [OP_W-1:0] OP_AND  = 5'h03;
    localparam logic [OP_W-1:0] OP_OR   = 5'h04;
    localparam logic [OP_W-1:0] OP_XOR  = 5'h05;
    localparam logic [OP_W-1:0] OP_SLT  = 5'h06;
    localparam logic [OP_W-1:0] OP_LI   = 5'h08;
    localparam logic [OP_W-1:0] OP_ADDI = 5'h09;
    localparam logic [OP_W-1:0] OP_LD   = 5'h0A;
    localparam logic [OP_W-1:0] OP_ST   = 5'h0B;
    localparam logic [OP_W-1:0] OP_JMP  = 5'h0C;
    localparam logic [OP_W-1:0] OP_JAL  = 5'h0D;
    localparam logic [OP_W-1:0] OP_JMPR = 5'h0E;
    localparam logic [OP_W-1:0] OP_BR   = 5'h0F;
    localparam logic [OP_W-1:0] OP_CMP  = 5'h10;

    localparam logic [AOP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [AOP_W-1:0] ALU_CMP  = 3'b001;
    localparam logic [AOP_W-1:0] ALU_ADDI = 3'b011;
    localparam logic [AOP_W-1:0] ALU_LI   = 3'b110;

    localparam int unsigned CB_MEM2REG  = 10;
    localparam int unsigned CB_MEMWRITE = 9;
    localparam int unsigned CB_MEMREAD  = 8;
    localparam int unsigned CB_ALUSRC1  = 7;
    localparam int unsigned CB_ALUSRC2  = 6;
    localparam int unsigned CB_REGWRITE = 5;
    localparam int unsigned CB_JUMP     = 4;
    localparam int unsigned CB_BRANCH   = 3;
    localparam int unsigned CB_JAL      = 2;
    localparam int unsigned CB_REGREAD  = 1;
    localparam int unsigned CB_ILLEGAL  = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [AOP_W-1:0]  aluop;
    } dec_t;

    function automatic dec_t decode(input logic [OP_W-1:0] op, input logic imm);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                d.ctrl[CB_REGWRITE] = 1'b1;
                d.ctrl[CB_REGREAD]  = 1'b1;
                d.ctrl[CB_ALUSRC1]  = 1'b1;
                d.ctrl[CB_ALUSRC2]  = ~imm;
                d.aluop             = AOP_W'(op - OP_ADD);
            end
            OP_LI: begin
                d.ctrl[CB_REGWRITE] = 1'b1;
                d.aluop             = ALU_LI;
            end
            OP_ADDI: begin
                d.ctrl[CB_REGWRITE] = 1'b1;
                d.ctrl[CB_REGREAD]  = 1'b1;
                d.ctrl[CB_ALUSRC1]  = 1'b1;
                d.aluop             = ALU_ADDI;
            end
            OP_LD: begin
                d.ctrl[CB_MEMREAD]  = 1'b1;
                d.ctrl[CB_MEM2REG]  = 1'b1;
                d.ctrl[CB_REGWRITE] = 1'b1;
                d.ctrl[CB_REGREAD]  = 1'b1;
                d.ctrl[CB_ALUSRC1]  = 1'b1;
                d.aluop             = ALU_ADD;
            end
            OP_ST: begin
                d.ctrl[CB_MEMWRITE] = 1'b1;
                d.ctrl[CB_REGREAD]  = 1'b1;
                d.ctrl[CB_ALUSRC1]  = 1'b1;
            end
            OP_JMP, OP_JMPR: begin
                d.ctrl[CB_JUMP]    = 1'b1;
                d.ctrl[CB_REGREAD] = 1'b1;
                d.ctrl[CB_ALUSRC1] = 1'b1;
            end
            OP_JAL: begin
                d.ctrl[CB_JUMP]     = 1'b1;
                d.ctrl[CB_JAL]      = 1'b1;
                d.ctrl[CB_REGWRITE] = 1'b1;
                d.ctrl[CB_REGREAD]  = 1'b1;
                d.ctrl[CB_ALUSRC1]  = 1'b1;
            end
            OP_BR: d.ctrl[CB_BRANCH] = 1'b1;
            OP_CMP: begin
                d.ctrl[CB_REGREAD] = 1'b1;
                d.ctrl[CB_ALUSRC1] = 1'b1;
                d.ctrl[CB_ALUSRC2] = ~imm;
                d.aluop            = ALU_CMP;
            end
            default: d.ctrl[CB_ILLEGAL] = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of
// a load still sitting in the ID/EX register.
module ctrl_hazard_detect #(
    parameter int unsigned RADDR_W = 5
) (
    input  logic               out_valid,
    input  logic               mem_read,
    input  logic [RADDR_W-1:0] rd_q,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    input  logic               uses_rs2,
    output logic               stall
);

    always_comb begin
        stall = out_valid & mem_read & (rd_q != '0)
              & ((rs1 == rd_q) | ((rs2 == rd_q) & uses_rs2));
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID -> ID/EX registered decode stage with load-use stall, flush and handshakes.
// Define CTRL_PERF_CNT_EN to add saturating stall/flush cycle counters.
module ctrl_decode_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W     = OP_W,
    parameter int unsigned ALUOP_W      = AOP_W,
    parameter int unsigned RADDR_W      = RA_W,
    parameter bit          ILLEGAL_PASS = 1'b1
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W        = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imm_sel,
    input  logic [RADDR_W-1:0]  rs1,
    input  logic [RADDR_W-1:0]  rs2,
    input  logic [RADDR_W-1:0]  rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   ctrl_q,
    output logic [ALUOP_W-1:0]  aluop_q,
    output logic [RADDR_W-1:0]  rd_q,
`ifdef CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
`endif
    output logic                stall
);

    dec_t dec;
    logic uses_rs2;
    logic accept;

    always_comb begin
        dec      = decode(opcode, imm_sel);
        uses_rs2 = (dec.ctrl[CB_REGREAD] & ~imm_sel) | (opcode == OP_ST);
    end

    ctrl_hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .out_valid (out_valid),
        .mem_read  (ctrl_q[CB_MEMREAD]),
        .rd_q      (rd_q),
        .rs1       (rs1),
        .rs2       (rs2),
        .uses_rs2  (uses_rs2),
        .stall     (stall)
    );

    always_comb begin
        in_ready = ~stall & (~out_valid | out_ready);
        accept   = in_valid & in_ready;
    end

    // Flush and bubbles clear the whole bundle so EX never sees stale fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            aluop_q   <= '0;
            rd_q      <= '0;
        end else if (flush || (!accept && stall && out_ready)) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            aluop_q   <= '0;
            rd_q      <= '0;
        end else if (accept) begin
            out_valid <= ~dec.ctrl[CB_ILLEGAL] | ILLEGAL_PASS;
            ctrl_q    <= dec.ctrl;
            aluop_q   <= dec.aluop;
            rd_q      <= rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: a cycle-level reference model predicts
// each registered bundle, a monitor pops and compares after every clock edge.
module tb_ctrl_decode_pipe;

    localparam bit PASS = 1'b1;
    localparam int B_ILL = 0, B_RR = 1, B_JAL = 2, B_BR = 3, B_J = 4, B_RW = 5;
    localparam int B_S2 = 6, B_S1 = 7, B_MR = 8, B_MW = 9, B_M2R = 10;

    typedef struct {
        bit          v;
        logic [10:0] c;
        logic [2:0]  a;
        logic [4:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  opcode = '0;
    logic        imm_sel = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [10:0] ctrl_q;
    logic [2:0]  aluop_q;
    logic [4:0]  rd_q;
    logic        stall;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
    int          m_scnt = 0, m_fcnt = 0;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    bit          m_v = 0;
    logic [10:0] m_c = '0;
    logic [2:0]  m_a = '0;
    logic [4:0]  m_rd = '0;

    ctrl_decode_pipe #(
        .ILLEGAL_PASS (PASS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .imm_sel   (imm_sel),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_q    (ctrl_q),
        .aluop_q   (aluop_q),
        .rd_q      (rd_q),
`ifdef CTRL_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference decode: returns {ctrl[10:0], aluop[2:0]} straight from the opcode table.
    function automatic logic [13:0] ref_decode(input int op, input bit imm);
        logic [10:0] c;
        int          alu;
        c   = '0;
        alu = 0;
        if (op >= 1 && op <= 6) begin
            c[B_RW] = 1; c[B_RR] = 1; c[B_S1] = 1; c[B_S2] = !imm; alu = op - 1;
        end else if (op == 8) begin
            c[B_RW] = 1; alu = 6;
        end else if (op == 9) begin
            c[B_RW] = 1; c[B_RR] = 1; c[B_S1] = 1; alu = 3;
        end else if (op == 10) begin
            c[B_MR] = 1; c[B_M2R] = 1; c[B_RW] = 1; c[B_RR] = 1; c[B_S1] = 1;
        end else if (op == 11) begin
            c[B_MW] = 1; c[B_RR] = 1; c[B_S1] = 1;
        end else if (op == 12 || op == 14) begin
            c[B_J] = 1; c[B_RR] = 1; c[B_S1] = 1;
        end else if (op == 13) begin
            c[B_J] = 1; c[B_JAL] = 1; c[B_RW] = 1; c[B_RR] = 1; c[B_S1] = 1;
        end else if (op == 15) begin
            c[B_BR] = 1;
        end else if (op == 16) begin
            c[B_RR] = 1; c[B_S1] = 1; c[B_S2] = !imm; alu = 1;
        end else begin
            c[B_ILL] = 1;
        end
        return {c, 3'(alu)};
    endfunction

    // One clock of stimulus: drive, check the combinational outputs, advance the model.
    task automatic step(input bit iv, input int op, input bit imm, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rdd, input bit fl,
                        input bit ordy);
        logic [13:0] d;
        logic [10:0] dc;
        bit          st, rdy, u2;
        exp_t        e;
        @(negedge clk);
        in_valid = iv; opcode = 5'(op); imm_sel = imm;
        rs1 = r1; rs2 = r2; rd = rdd; flush = fl; out_ready = ordy;
        #1;
        d  = ref_decode(op, imm);
        dc = d[13:3];
        u2 = (dc[B_RR] && !imm) || op == 11;
        st = m_v && m_c[B_MR] && m_rd != 0 && (r1 == m_rd || (r2 == m_rd && u2));
        rdy = !st && (!m_v || ordy);
        chk("stall", 32'(stall), 32'(st));
        chk("in_ready", 32'(in_ready), 32'(rdy));
`ifdef CTRL_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
        if (st && m_scnt < 65535) m_scnt++;
        if (fl && m_fcnt < 65535) m_fcnt++;
`endif
        if (fl) begin
            m_v = 0; m_c = '0;
        end else if (iv && rdy) begin
            m_c = dc; m_a = d[2:0]; m_rd = rdd; m_v = !dc[B_ILL] || PASS;
        end else if (st && ordy) begin
            m_v = 0; m_c = '0;
        end else if (ordy) begin
            m_v = 0;
        end
        e = '{m_v, m_c, m_a, m_rd};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl_q", 32'(ctrl_q), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        exp_q.delete();
        m_v = 0; m_c = '0; m_a = '0; m_rd = '0;
`ifdef CTRL_PERF_CNT_EN
        m_scnt = 0; m_fcnt = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every edge produces exactly one predicted register state.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("ctrl_q", 32'(ctrl_q), 32'(e.c));
            if (e.v) begin
                chk("aluop_q", 32'(aluop_q), 32'(e.a));
                chk("rd_q", 32'(rd_q), 32'(e.r));
            end
        end
    end

    initial begin
        do_reset();

        // ADD with immediate operand.
        step(1, 1, 1, 5'd1, 5'd2, 5'd5, 0, 1);
        @(posedge clk); #2;
        chk("add_aluop", 32'(aluop_q), 32'd0);
        chk("add_src2", 32'(ctrl_q[B_S2]), 32'd0);
        chk("add_regwrite", 32'(ctrl_q[B_RW]), 32'd1);
        chk("add_valid", 32'(out_valid), 32'd1);

        // Load-use: load r3 then ADD reading r3 stalls once.
        step(1, 10, 0, 5'd0, 5'd0, 5'd3, 0, 1);
        step(1, 1, 0, 5'd3, 5'd0, 5'd4, 0, 1);
        step(1, 1, 0, 5'd3, 5'd0, 5'd4, 0, 1);
        // Back-to-back loads: independent second load, then dependent one.
        step(1, 10, 0, 5'd1, 5'd0, 5'd2, 0, 1);
        step(1, 10, 0, 5'd0, 5'd1, 5'd6, 0, 1);
        step(1, 10, 0, 5'd6, 5'd0, 5'd7, 0, 1);
        step(1, 10, 0, 5'd6, 5'd0, 5'd7, 0, 1);

        // Flush coincident with a stall and a valid ID instruction.
        step(1, 10, 0, 5'd0, 5'd0, 5'd3, 0, 1);
        step(1, 1, 0, 5'd3, 5'd0, 5'd4, 1, 1);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);

        // Back-pressure for three cycles, then resume.
        step(1, 2, 0, 5'd1, 5'd1, 5'd8, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 9, 1, 5'd2, 5'd2, 5'd9, 0, 0);
        step(1, 9, 1, 5'd2, 5'd2, 5'd9, 0, 1);
        step(1, 11, 0, 5'd9, 5'd9, 5'd0, 0, 1);

        // Illegal opcode and store rs2 dependency.
        step(1, 31, 0, 5'd0, 5'd0, 5'd1, 0, 1);
        step(1, 10, 0, 5'd0, 5'd0, 5'd5, 0, 1);
        step(1, 11, 1, 5'd0, 5'd5, 5'd0, 0, 1);
        step(1, 11, 1, 5'd0, 5'd5, 5'd0, 0, 1);

        // Reset in the middle of a stall.
        step(1, 10, 0, 5'd0, 5'd0, 5'd2, 0, 1);
        step(1, 1, 0, 5'd2, 5'd0, 5'd3, 0, 0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(0, 31));
            step($urandom_range(0, 4) != 0, op, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
            if (i == 1500) do_reset();
        end

        @(posedge clk); #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
